// File: rtl/mem_result_checker.sv
// ----------------------------------------------------------------------------
// mem_result_checker
//
// Walks the CPU data memory and an expected-image ROM in lock-step, one word
// per clock, and compares the two images word by word. Reports the number of
// differing words (saturating) and the index/contents of the first mismatch.
// Can optionally stop at the first mismatch.
//
// Ports
//   clk            : sole clock, rising edge
//   rst            : asynchronous, active-high reset
//   start          : begin a compare pass (accepted only in IDLE or DONE)
//   stop_on_first  : halt at first mismatch; captured together with start
//   mem_addr       : word index to data-memory read port
//   mem_rdata      : data-memory word, valid one cycle after mem_addr
//   ans_addr       : word index to expected-image ROM (mirrors mem_addr)
//   ans_rdata      : expected word, same latency as mem_rdata
//   busy           : pass in progress (SCAN or DRAIN)
//   done           : pass finished; held until next accepted start or reset
//   pass           : done with zero mismatches
//   mismatch_count : differing words in this pass, saturating
//   first_addr     : index of the first mismatch
//   first_got      : memory word of the first mismatch
//   first_exp      : expected word of the first mismatch
// ----------------------------------------------------------------------------
module mem_result_checker #(
    parameter int RAM_SIZE = 4096,
    parameter int AW       = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          stop_on_first,
    output logic [AW-1:0] mem_addr,
    input  logic [31:0]   mem_rdata,
    output logic [AW-1:0] ans_addr,
    input  logic [31:0]   ans_rdata,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [31:0]   mismatch_count,
    output logic [AW-1:0] first_addr,
    output logic [31:0]   first_got,
    output logic [31:0]   first_exp
);

    localparam int            N         = RAM_SIZE / 4;
    localparam logic [AW-1:0] LAST_ADDR = AW'(N - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_next;

    logic [AW-1:0] r_mem_addr;
    logic          r_sof;          // stop_on_first captured at accept
    logic          r_p1_vld;       // an index was issued last cycle
    logic [AW-1:0] r_p1_idx;       // that index; its data is on *_rdata now
    logic          r_done;
    logic          r_pass;
    logic [31:0]   r_count;
    logic [AW-1:0] r_first_addr;
    logic [31:0]   r_first_got;
    logic [31:0]   r_first_exp;

    logic          w_accept;
    logic          w_mis;
    logic          w_stop;
    logic          w_last;

    assign w_accept = ((r_state == IDLE) || (r_state == DONE)) && start;
    assign w_mis    = r_p1_vld && (mem_rdata != ans_rdata);
    assign w_stop   = w_mis && r_sof;
    assign w_last   = r_p1_vld && (r_p1_idx == LAST_ADDR);

    // ---------------- FSM state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- FSM next-state ----------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    w_state_next = SCAN;
                end
            end
            SCAN: begin
                if (w_stop) begin
                    w_state_next = DONE;
                end else if (r_mem_addr == LAST_ADDR) begin
                    w_state_next = DRAIN;
                end
            end
            DRAIN: begin
                // The final word's compare is the one that closes the pass.
                if (w_stop || w_last) begin
                    w_state_next = DONE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // ---------------- Address, compare pipeline and results ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem_addr   <= '0;
            r_sof        <= 1'b0;
            r_p1_vld     <= 1'b0;
            r_p1_idx     <= '0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_count      <= '0;
            r_first_addr <= '0;
            r_first_got  <= '0;
            r_first_exp  <= '0;
        end else if (w_accept) begin
            r_mem_addr   <= '0;
            r_sof        <= stop_on_first;
            r_p1_vld     <= 1'b0;
            r_p1_idx     <= '0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_count      <= '0;
            r_first_addr <= '0;
            r_first_got  <= '0;
            r_first_exp  <= '0;
        end else begin
            // An early stop drops whatever index is still in flight.
            r_p1_vld <= (r_state == SCAN) && !w_stop;
            r_p1_idx <= r_mem_addr;

            if ((r_state == SCAN) && !w_stop && (r_mem_addr != LAST_ADDR)) begin
                r_mem_addr <= r_mem_addr + 1'b1;
            end

            if (w_mis) begin
                if (r_count != 32'hFFFF_FFFF) begin
                    r_count <= r_count + 32'd1;
                end
                if (r_count == 32'd0) begin
                    r_first_addr <= r_p1_idx;
                    r_first_got  <= mem_rdata;
                    r_first_exp  <= ans_rdata;
                end
            end

            if (w_stop) begin
                r_done <= 1'b1;
                r_pass <= 1'b0;
            end else if ((r_state == DRAIN) && w_last) begin
                r_done <= 1'b1;
                // Include the verdict of the word being compared on this edge.
                r_pass <= (r_count == 32'd0) && !w_mis;
            end
        end
    end

    assign mem_addr       = r_mem_addr;
    assign ans_addr       = r_mem_addr;
    assign busy           = (r_state == SCAN) || (r_state == DRAIN);
    assign done           = r_done;
    assign pass           = r_pass;
    assign mismatch_count = r_count;
    assign first_addr     = r_first_addr;
    assign first_got      = r_first_got;
    assign first_exp      = r_first_exp;

endmodule

// File: tb/tb_mem_result_checker.sv
// ----------------------------------------------------------------------------
// tb_mem_result_checker
//
// Directed bench for mem_result_checker with RAM_SIZE=64 (16 words). Two
// behavioural synchronous-read memories supply the data and expected images.
// Outputs are sampled 1 ns after each rising edge; E0 is the accepting edge.
// ----------------------------------------------------------------------------
module tb_mem_result_checker;

    localparam int RAM_SIZE = 64;
    localparam int AW       = 4;
    localparam int N        = RAM_SIZE / 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          stop_on_first;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_rdata = '0;
    logic [AW-1:0] ans_addr;
    logic [31:0]   ans_rdata = '0;
    logic          busy;
    logic          done;
    logic          pass;
    logic [31:0]   mismatch_count;
    logic [AW-1:0] first_addr;
    logic [31:0]   first_got;
    logic [31:0]   first_exp;

    logic [31:0]   dmem [N];
    logic [31:0]   amem [N];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        mem_rdata <= dmem[mem_addr];
        ans_rdata <= amem[ans_addr];
    end

    mem_result_checker #(
        .RAM_SIZE (RAM_SIZE),
        .AW       (AW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .stop_on_first  (stop_on_first),
        .mem_addr       (mem_addr),
        .mem_rdata      (mem_rdata),
        .ans_addr       (ans_addr),
        .ans_rdata      (ans_rdata),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .mismatch_count (mismatch_count),
        .first_addr     (first_addr),
        .first_got      (first_got),
        .first_exp      (first_exp)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_addr"},  32'(mem_addr), 32'd0);
        chk({tag, "_busy"},  32'(busy), 32'd0);
        chk({tag, "_done"},  32'(done), 32'd0);
        chk({tag, "_pass"},  32'(pass), 32'd0);
        chk({tag, "_count"}, mismatch_count, 32'd0);
        chk({tag, "_faddr"}, 32'(first_addr), 32'd0);
        chk({tag, "_fgot"},  first_got, 32'd0);
        chk({tag, "_fexp"},  first_exp, 32'd0);
    endtask

    initial begin
        rst           = 1'b1;
        start         = 1'b0;
        stop_on_first = 1'b0;
        for (int i = 0; i < N; i++) begin
            dmem[i] = 32'h1000_0000 + 32'(i);
            amem[i] = 32'h1000_0000 + 32'(i);
        end

        // ---- Reset state ----
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("rst");
        rst = 1'b0;
        $display("reset: busy=%0d done=%0d count=%0d", busy, done, mismatch_count);

        // ---- S1: identical images; start on first edge after release ----
        start = 1'b1;
        for (int e = 0; e < 18; e++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            chk($sformatf("s1_addr_E%0d", e), 32'(mem_addr), (e <= 15) ? 32'(e) : 32'd15);
            chk($sformatf("s1_ans_addr_E%0d", e), 32'(ans_addr), (e <= 15) ? 32'(e) : 32'd15);
            chk($sformatf("s1_busy_E%0d", e), 32'(busy), (e <= 16) ? 32'd1 : 32'd0);
            chk($sformatf("s1_done_E%0d", e), 32'(done), (e == 17) ? 32'd1 : 32'd0);
        end
        chk("s1_pass", 32'(pass), 32'd1);
        chk("s1_count", mismatch_count, 32'd0);
        $display("S1 identical: done=%0d pass=%0d count=%0d", done, pass, mismatch_count);

        // ---- S2: words 3 and 9 corrupted, no early stop; start from DONE ----
        dmem[3] = 32'hDEAD_BEEF;
        dmem[9] = 32'hDEAD_BEEF;
        stop_on_first = 1'b0;
        start = 1'b1;
        for (int e = 0; e < 18; e++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (e == 0) begin
                chk("s2_clear_done", 32'(done), 32'd0);
                chk("s2_clear_pass", 32'(pass), 32'd0);
            end
            chk($sformatf("s2_count_E%0d", e), mismatch_count,
                (e >= 11) ? 32'd2 : ((e >= 5) ? 32'd1 : 32'd0));
            chk($sformatf("s2_done_E%0d", e), 32'(done), (e == 17) ? 32'd1 : 32'd0);
        end
        chk("s2_pass", 32'(pass), 32'd0);
        chk("s2_faddr", 32'(first_addr), 32'd3);
        chk("s2_fgot", first_got, 32'hDEAD_BEEF);
        chk("s2_fexp", first_exp, 32'h1000_0003);
        $display("S2 two errors: count=%0d first_addr=%0d got=%h exp=%h",
                 mismatch_count, first_addr, first_got, first_exp);

        // ---- S3: same images, stop on first ----
        stop_on_first = 1'b1;
        start = 1'b1;
        for (int e = 0; e < 10; e++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            stop_on_first = 1'b0;
            if (e == 0) begin
                chk("s3_clear_faddr", 32'(first_addr), 32'd0);
                chk("s3_clear_fgot", first_got, 32'd0);
                chk("s3_clear_count", mismatch_count, 32'd0);
            end
            chk($sformatf("s3_done_E%0d", e), 32'(done), (e >= 5) ? 32'd1 : 32'd0);
            chk($sformatf("s3_busy_E%0d", e), 32'(busy), (e < 5) ? 32'd1 : 32'd0);
            chk($sformatf("s3_count_E%0d", e), mismatch_count, (e >= 5) ? 32'd1 : 32'd0);
            chk($sformatf("s3_addr_E%0d", e), 32'(mem_addr), (e < 5) ? 32'(e) : 32'd4);
        end
        chk("s3_pass", 32'(pass), 32'd0);
        chk("s3_faddr", 32'(first_addr), 32'd3);
        $display("S3 stop-on-first: count=%0d first_addr=%0d mem_addr=%0d",
                 mismatch_count, first_addr, mem_addr);

        // ---- S4: only the last word differs ----
        dmem[3]  = 32'h1000_0003;
        dmem[9]  = 32'h1000_0009;
        dmem[15] = 32'h0BAD_0BAD;
        start = 1'b1;
        for (int e = 0; e < 18; e++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            chk($sformatf("s4_count_E%0d", e), mismatch_count, (e == 17) ? 32'd1 : 32'd0);
            chk($sformatf("s4_done_E%0d", e), 32'(done), (e == 17) ? 32'd1 : 32'd0);
            chk($sformatf("s4_busy_E%0d", e), 32'(busy), (e <= 16) ? 32'd1 : 32'd0);
        end
        chk("s4_pass", 32'(pass), 32'd0);
        chk("s4_faddr", 32'(first_addr), 32'd15);
        chk("s4_fgot", first_got, 32'h0BAD_0BAD);
        chk("s4_fexp", first_exp, 32'h1000_000F);
        $display("S4 last word: count=%0d first_addr=%0d got=%h",
                 mismatch_count, first_addr, first_got);

        // ---- S5: reset mid-scan (word 2 corrupted so state is non-zero) ----
        dmem[15] = 32'h1000_000F;
        dmem[2]  = 32'h5555_5555;
        start = 1'b1;
        for (int e = 0; e < 9; e++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            chk($sformatf("s5_count_E%0d", e), mismatch_count, (e >= 4) ? 32'd1 : 32'd0);
        end
        #1;
        rst = 1'b1;
        #1;
        chk_all_zero("s5_async_rst");
        rst = 1'b0;
        dmem[2] = 32'h1000_0002;
        for (int e = 0; e < 3; e++) begin
            @(posedge clk);
            #1;
            chk($sformatf("s5_idle_done_%0d", e), 32'(done), 32'd0);
            chk($sformatf("s5_idle_busy_%0d", e), 32'(busy), 32'd0);
        end
        $display("S5 mid-scan reset: busy=%0d done=%0d count=%0d", busy, done, mismatch_count);

        // ---- S6: new pass with start re-asserted at E4 while busy ----
        start = 1'b1;
        for (int e = 0; e < 18; e++) begin
            @(posedge clk);
            #1;
            start = (e == 3);
            chk($sformatf("s6_addr_E%0d", e), 32'(mem_addr), (e <= 15) ? 32'(e) : 32'd15);
            chk($sformatf("s6_busy_E%0d", e), 32'(busy), (e <= 16) ? 32'd1 : 32'd0);
            chk($sformatf("s6_done_E%0d", e), 32'(done), (e == 17) ? 32'd1 : 32'd0);
        end
        chk("s6_pass", 32'(pass), 32'd1);
        chk("s6_count", mismatch_count, 32'd0);
        $display("S6 restart after reset: done=%0d pass=%0d count=%0d", done, pass, mismatch_count);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
